// File: rtl/console_pkg.sv
// Shared console constants and the spawn position generator state type.
package console_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned RND_W    = 10;
  localparam int unsigned POS_X_W  = 10;
  localparam int unsigned POS_Y_W  = 9;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic [2:0] {
    SPG_IDLE,
    SPG_REDUCE_X,
    SPG_SAMPLE_Y,
    SPG_REDUCE_Y,
    SPG_DONE
  } spawn_state_e;

endpackage

// File: rtl/spawn_pos_gen_if.sv
// Request/acknowledge handshake and result bus between a spawn consumer and spawn_pos_gen.
interface spawn_if;
  import console_pkg::*;

  logic               spawn_req;
  logic               spawn_ready;
  logic               spawn_valid;
  logic               spawn_ack;
  logic [POS_X_W-1:0] pos_x;
  logic [POS_Y_W-1:0] pos_y;
  logic [CNT_W-1:0]   spawn_count;

  modport master (
    output spawn_req, spawn_ack,
    input  spawn_ready, spawn_valid, pos_x, pos_y, spawn_count
  );

  modport slave (
    input  spawn_req, spawn_ack,
    output spawn_ready, spawn_valid, pos_x, pos_y, spawn_count
  );

endinterface

// File: rtl/spawn_pos_gen.sv
// Turns upstream LFSR words into an on-screen (x,y) spawn position by repeated
// subtraction, using one subtract/compare path shared by both axes.
module spawn_pos_gen
  import console_pkg::*;
#(
  parameter int unsigned MAX_X = SCREEN_W,
  parameter int unsigned MAX_Y = SCREEN_H
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RND_W-1:0] rnd_value,
  spawn_if.slave           spawn
);

  localparam logic [RND_W-1:0] LIM_X = RND_W'(MAX_X);
  localparam logic [RND_W-1:0] LIM_Y = RND_W'(MAX_Y);

  spawn_state_e       state_q;
  logic [RND_W-1:0]   work_q;
  logic [POS_X_W-1:0] pos_x_q;
  logic [POS_Y_W-1:0] pos_y_q;
  logic [CNT_W-1:0]   count_q;
  logic               ready_q;
  logic               valid_q;

  logic [RND_W-1:0]   limit_c;
  logic [RND_W-1:0]   work_sub_c;
  logic               over_c;

  // Shared reduction datapath; equality counts as out of range.
  always_comb begin
    limit_c    = (state_q == SPG_REDUCE_X) ? LIM_X : LIM_Y;
    over_c     = (work_q >= limit_c);
    work_sub_c = work_q - limit_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SPG_IDLE;
      work_q  <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        SPG_IDLE: begin
          if (spawn.spawn_req && ready_q) begin
            work_q  <= rnd_value;
            ready_q <= 1'b0;
            state_q <= SPG_REDUCE_X;
          end
        end
        SPG_REDUCE_X: begin
          if (over_c) begin
            work_q <= work_sub_c;
          end else begin
            pos_x_q <= POS_X_W'(work_q);
            state_q <= SPG_SAMPLE_Y;
          end
        end
        // Y comes from a later LFSR word than X.
        SPG_SAMPLE_Y: begin
          work_q  <= rnd_value;
          state_q <= SPG_REDUCE_Y;
        end
        SPG_REDUCE_Y: begin
          if (over_c) begin
            work_q <= work_sub_c;
          end else begin
            pos_y_q <= work_q[POS_Y_W-1:0];
            valid_q <= 1'b1;
            state_q <= SPG_DONE;
          end
        end
        SPG_DONE: begin
          if (spawn.spawn_ack) begin
            count_q <= count_q + CNT_W'(1);
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= SPG_IDLE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          state_q <= SPG_IDLE;
        end
      endcase
    end
  end

  assign spawn.spawn_ready = ready_q;
  assign spawn.spawn_valid = valid_q;
  assign spawn.pos_x       = pos_x_q;
  assign spawn.pos_y       = pos_y_q;
  assign spawn.spawn_count = count_q;

endmodule

// File: doc/spawn_pos_gen.md
SPAWN_POS_GEN -- requirements
Module: spawn_pos_gen

Interface
REQ-001 Parameter MAX_X, default 640, exclusive upper bound of pos_x; legal range 1..1023.
REQ-002 Parameter MAX_Y, default 480, exclusive upper bound of pos_y; legal range 1..512.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; reset==0 forces the reset state immediately.
REQ-005 rnd_value  in  10  free-running pseudo-random word from the upstream LFSR (value output), sampled as-is.
REQ-006 spawn_req  in  1  request for a new (x,y) spawn position.
REQ-007 spawn_ready  out  1  high only in IDLE; spawn_req is accepted on an edge where spawn_req && spawn_ready.
REQ-008 spawn_valid  out  1  high only in DONE; pos_x/pos_y are valid.
REQ-009 spawn_ack  in  1  consumer acknowledge; the handshake completes on an edge where spawn_valid && spawn_ack.
REQ-010 pos_x  out  10  spawn x coordinate, always < MAX_X when spawn_valid.
REQ-011 pos_y  out  9  spawn y coordinate, always < MAX_Y when spawn_valid.
REQ-012 spawn_count  out  8  number of completed handshakes, modulo 256.

Function
REQ-013 FSM states: IDLE, REDUCE_X, SAMPLE_Y, REDUCE_Y, DONE.
REQ-014 IDLE: on acceptance, work <= rnd_value (10-bit register); next state REDUCE_X; otherwise stay in IDLE.
REQ-015 REDUCE_X: if work >= MAX_X, work <= work - MAX_X and stay; else pos_x <= work, next SAMPLE_Y.
REQ-016 SAMPLE_Y: work <= rnd_value; next REDUCE_Y. This forces the Y sample onto a later LFSR word than X.
REQ-017 REDUCE_Y: if work >= MAX_Y, work <= work - MAX_Y and stay; else pos_y <= work[8:0], next DONE.
REQ-018 DONE: hold pos_x, pos_y stable; on spawn_ack, spawn_count <= spawn_count + 1 (255 wraps to 0); next IDLE.
REQ-019 Latency: spawn_valid rises kx+ky+3 cycles after the acceptance edge.
   - kx = floor(x sample / MAX_X); ky = floor(y sample / MAX_Y).
   - With defaults: minimum 3 cycles, maximum 6 cycles (both samples 1023).
REQ-020 Comparisons are unsigned.
   - Equality counts as out of range: work == MAX_X or work == MAX_Y is reduced.
   - Subtraction never underflows.
REQ-021 spawn_req while not in IDLE is ignored; it is neither queued nor counted.
REQ-022 spawn_ack outside DONE is ignored.
REQ-023 spawn_req high in DONE in the same cycle as spawn_ack:
   - the handshake completes;
   - the request is not accepted until the next IDLE cycle (no back-to-back acceptance in DONE).
REQ-024 pos_x and pos_y retain their last values outside DONE; they change only at the latch points in REQ-015 and REQ-017.

Reset
REQ-025 reset==0 at any time, including mid-reduction or in DONE, aborts the operation immediately.
   - Values: state=IDLE, work=0, pos_x=0, pos_y=0, spawn_count=0, spawn_valid=0, spawn_ready=1.
REQ-026 A request pending at reset is discarded; the first acceptance is possible on the first edge after reset returns to 1.

Structure
REQ-027 Shared package console_pkg holds:
   - SCREEN_W=640 and SCREEN_H=480, used as the MAX_X/MAX_Y defaults;
   - RND_W=10;
   - the spawn_pos_gen state enum.
REQ-028 One shared subtract/compare datapath on work serves both axes.
   - No sub-module is instantiated.
   - The LFSR is connected at the parent level, not inside this block.

Verification
REQ-029 Nominal: rnd_value=100 at accept, 300 at SAMPLE_Y -> pos=(100,300), spawn_valid 3 cycles after accept.
REQ-030 Maximum reduction: rnd_value=1023 on both samples -> pos=(383,63), spawn_valid 6 cycles after accept.
REQ-031 Boundaries: x sample 640 and y sample 480 -> pos=(0,0); x sample 639 and y sample 479 -> pos=(639,479).
REQ-032 Hold and wrap:
   - spawn_ack low for 10 cycles in DONE -> outputs stable and spawn_valid held high;
   - after ack, spawn_ready=1 the next cycle;
   - 256 completed handshakes -> spawn_count returns to 0.
REQ-033 Ignored request: spawn_req pulsed during REDUCE_X -> exactly one result and spawn_count +1 only.
REQ-034 Reset mid-operation: reset=0 during REDUCE_Y -> all outputs take the REQ-025 values immediately, with no clock edge needed.
